matrix_read_sequencer: RTL and testbench

//   Read-side controller for the double-buffered matrix frame store, in the I_clkb domain.

---
 rtl/matrix_read_sequencer_if.sv | 25 ++
 rtl/matrix_read_sequencer.sv | 139 +++++++++++++
 tb/tb_matrix_read_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_read_sequencer_if.sv
// Read-side bus of the matrix frame store: RAM read port plus the lane stream
// towards the serialisers. master = sequencer, slave = RAM/serialiser side.
interface matrix_read_sequencer_if #(
  parameter int LANES  = 12,
  parameter int LANE_W = 8,
  parameter int AW     = 12
);
  logic                      O_read_enable;
  logic [AW-1:0]             O_read_address;
  logic [LANES*LANE_W-1:0]   I_read_data_flat;
  logic [LANES*LANE_W-1:0]   O_lane_data_flat;
  logic                      O_lane_valid;
  logic                      I_lane_ready;
  logic                      O_lane_last;

  modport master (
    output O_read_enable, O_read_address, O_lane_data_flat, O_lane_valid, O_lane_last,
    input  I_read_data_flat, I_lane_ready
  );

  modport slave (
    input  O_read_enable, O_read_address, O_lane_data_flat, O_lane_valid, O_lane_last,
    output I_read_data_flat, I_lane_ready
  );
endinterface

// File: rtl/matrix_read_sequencer.sv
// Walks every address of the read bank after a buffer swap and streams the lane
// bytes downstream, hiding the RAM read latency behind a credit-gated skid FIFO.
//
// state    | meaning
// S_IDLE   | waiting for a pending swap with enable and data_valid
// S_STREAM | issuing reads 0..ADDRESS_NUMBER_B-1 as FIFO credit allows
// S_DRAIN  | all reads issued, waiting for the last beat to be accepted
module matrix_read_sequencer #(
  parameter int BYTES_PER_BLOCK    = 2250,
  parameter int BANK_COUNT         = 6,
  parameter int BLOCK_COUNT        = 2,
  parameter int BLOCK_DATA_WIDTH_B = 8,
  parameter int READ_LATENCY       = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic I_clkb,
  input  logic I_rst_n,
  input  logic I_enable,
  input  logic I_buffer_updated,
  input  logic I_data_valid,
  output logic O_frame_start,
  output logic O_frame_done,
  output logic O_busy,
  output logic O_overrun,
  matrix_read_sequencer_if.master bus
);
  localparam int LANES            = BANK_COUNT * BLOCK_COUNT;
  localparam int DW               = LANES * BLOCK_DATA_WIDTH_B;
  localparam int ADDRESS_NUMBER_B = (BYTES_PER_BLOCK * 8) / BLOCK_DATA_WIDTH_B;
  localparam int AW               = $clog2(ADDRESS_NUMBER_B);
  localparam int PW               = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW               = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ADDRESS_NUMBER_B - 1);
  localparam logic [PW-1:0] PTR_MAX   = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t               state;
  logic [AW-1:0]        addr;
  logic                 pending;
  logic                 frame_start_q, frame_done_q, overrun_q;

  logic [READ_LATENCY-1:0] pipe_vld, pipe_last;
  logic [DW-1:0]        fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        fifo_count, inflight;
  logic                 issue, start, push, pop, last_accept;

  // Credit covers both stored entries and reads still in the RAM pipe, so a
  // full stall can never overflow the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(pipe_vld[i]);
    issue       = (state == S_STREAM) && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
    start       = (state == S_IDLE) && I_enable && I_data_valid && (pending || I_buffer_updated);
    push        = pipe_vld[READ_LATENCY-1];
    pop         = bus.O_lane_valid && bus.I_lane_ready;
    last_accept = pop && bus.O_lane_last;
  end

  assign bus.O_read_enable    = issue;
  assign bus.O_read_address   = addr;
  assign bus.O_lane_valid     = (fifo_count != '0);
  assign bus.O_lane_data_flat = fifo_data[rd_ptr];
  assign bus.O_lane_last      = bus.O_lane_valid && fifo_last[rd_ptr];
  assign O_frame_start        = frame_start_q;
  assign O_frame_done         = frame_done_q;
  assign O_overrun            = overrun_q;
  assign O_busy               = (state != S_IDLE);

  always_ff @(posedge I_clkb or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= S_IDLE;
      addr          <= '0;
      pending       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= I_buffer_updated && pending;
      pending       <= start ? 1'b0 : (pending || I_buffer_updated);
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_STREAM;
            addr          <= '0;
            frame_start_q <= 1'b1;
          end
        end
        S_STREAM: begin
          if (issue) begin
            if (addr == LAST_ADDR) state <= S_DRAIN;
            else                   addr  <= addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (last_accept) begin
            state        <= S_IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clkb or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pipe_vld   <= '0;
      pipe_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_last  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && (addr == LAST_ADDR);
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      if (push) begin
        fifo_data[wr_ptr] <= bus.I_read_data_flat;
        fifo_last[wr_ptr] <= pipe_last[READ_LATENCY-1];
        wr_ptr            <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_read_sequencer.sv
// Scoreboard bench for matrix_read_sequencer: every issued read pushes its expected
// beat, every accepted beat is popped and compared.
`timescale 1ns/1ps
module tb_matrix_read_sequencer;
  localparam int RL = 2, FD = 4;
  localparam int LANES = 2, LW = 8, AN = 8, AW = 3, DW = LANES * LW;

  logic I_clkb = 1'b0, I_rst_n = 1'b0;
  logic I_enable = 1'b0, I_buffer_updated = 1'b0, I_data_valid = 1'b0;
  logic O_frame_start, O_frame_done, O_busy, O_overrun;

  matrix_read_sequencer_if #(.LANES(LANES), .LANE_W(LW), .AW(AW)) bus ();

  matrix_read_sequencer #(
    .BYTES_PER_BLOCK(8), .BANK_COUNT(1), .BLOCK_COUNT(2), .BLOCK_DATA_WIDTH_B(LW),
    .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .I_clkb(I_clkb), .I_rst_n(I_rst_n), .I_enable(I_enable),
    .I_buffer_updated(I_buffer_updated), .I_data_valid(I_data_valid),
    .O_frame_start(O_frame_start), .O_frame_done(O_frame_done),
    .O_busy(O_busy), .O_overrun(O_overrun), .bus(bus)
  );

  always #5 I_clkb = ~I_clkb;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b, b ^ 8'hFF};
  endfunction

  // RAM model: data for a strobe seen in cycle t is on the bus in cycle t+RL
  logic [DW-1:0] ram_s1 = '0, ram_s2 = '0;
  always @(posedge I_clkb) begin
    if (bus.O_read_enable) ram_s1 <= exp_data(int'(bus.O_read_address));
    ram_s2 <= ram_s1;
  end
  assign bus.I_read_data_flat = ram_s2;

  logic [DW:0] sb[$];
  logic [DW:0] held = '0, e;
  logic stalled_prev = 1'b0;
  int cyc = 0, exp_addr = 0, n_issued = 0, n_accepted = 0;
  int n_starts = 0, n_done = 0, n_overrun = 0;
  int done_cyc = -100, last_acc_cyc = -100, start_gap = 0;
  int first_issue_cyc = 0, last_issue_cyc = 0;

  always @(negedge I_clkb) begin
    cyc++;
    if (O_frame_done || (cyc == last_acc_cyc + 1))
      check("frame_done", O_frame_done, (cyc == last_acc_cyc + 1));
    if (O_frame_done) begin n_done++; done_cyc = cyc; end
    if (O_frame_start) begin exp_addr = 0; n_starts++; start_gap = cyc - done_cyc; end
    if (O_overrun) n_overrun++;
    if (bus.O_read_enable) begin
      check("rd_addr", bus.O_read_address, exp_addr);
      sb.push_back({(exp_addr == AN - 1), exp_data(exp_addr)});
      if (exp_addr == 0) first_issue_cyc = cyc;
      if (exp_addr == AN - 1) last_issue_cyc = cyc;
      exp_addr++;
      n_issued++;
      check("outstanding", ((n_issued - n_accepted) <= FD), 1);
    end
    if (stalled_prev) check("stall_hold", {bus.O_lane_last, bus.O_lane_data_flat}, held);
    if (bus.O_lane_valid && bus.I_lane_ready) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        check("beat_data", bus.O_lane_data_flat, e[DW-1:0]);
        check("beat_last", bus.O_lane_last, e[DW]);
      end
      n_accepted++;
      if (bus.O_lane_last) last_acc_cyc = cyc;
    end
    stalled_prev = bus.O_lane_valid && !bus.I_lane_ready;
    held = {bus.O_lane_last, bus.O_lane_data_flat};
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge I_clkb); #1; end
  endtask

  task automatic pulse_update();
    I_buffer_updated = 1'b1;
    tick(1);
    I_buffer_updated = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (n_done >= target) break;
      tick(1);
    end
    if (n_done < target) check("frame_timeout", n_done, target);
  endtask

  task automatic chk_zero(input string tag);
    check(tag, {bus.O_read_enable, bus.O_read_address, bus.O_lane_valid, bus.O_lane_last,
                bus.O_lane_data_flat, O_frame_start, O_frame_done, O_busy, O_overrun}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, s0, i0, o0, lat;
    logic [3:0] pat;
    bus.I_lane_ready = 1'b0;
    tick(3);
    chk_zero("reset_outputs");
    I_rst_n = 1'b1;
    tick(1);

    // 1: plain frame, ready always high
    I_enable = 1'b1; I_data_valid = 1'b1; bus.I_lane_ready = 1'b1;
    a0 = n_accepted; d0 = n_done;
    pulse_update();
    check("t1_start", O_frame_start, 1);
    check("t1_first_ren", bus.O_read_enable, 1);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge I_clkb);
      if (bus.O_lane_valid) begin lat = k; break; end
    end
    // pushed RL cycles after the strobe, visible at the FIFO head one cycle later
    check("t1_first_beat_lat", lat, RL + 1);
    wait_frames(d0 + 1, 100);
    check("t1_issue_span", last_issue_cyc - first_issue_cyc, AN - 1);
    check("t1_beats", n_accepted - a0, AN);
    check("t1_sb_empty", sb.size(), 0);

    // 2: ready pattern 1,0,0,1
    a0 = n_accepted; d0 = n_done; pat = 4'b1001;
    pulse_update();
    for (int i = 0; i < 100 && n_done < d0 + 1; i++) begin
      bus.I_lane_ready = pat[i % 4];
      tick(1);
    end
    bus.I_lane_ready = 1'b1;
    check("t2_done", n_done, d0 + 1);
    check("t2_beats", n_accepted - a0, AN);
    check("t2_sb_empty", sb.size(), 0);

    // 3: update mid-frame queues a back-to-back frame, a third one overruns
    tick(2);
    d0 = n_done; s0 = n_starts; o0 = n_overrun;
    pulse_update();
    tick(2);
    pulse_update();
    check("t3_no_overrun", O_overrun, 0);
    tick(1);
    pulse_update();
    check("t3_overrun", O_overrun, 1);
    wait_frames(d0 + 2, 200);
    check("t3_b2b_gap", start_gap, 1);
    tick(6);
    check("t3_starts", n_starts - s0, 2);
    check("t3_overruns", n_overrun - o0, 1);
    check("t3_idle", O_busy, 0);

    // 4: start gated by enable, then by data_valid
    d0 = n_done; s0 = n_starts; i0 = n_issued;
    I_enable = 1'b0;
    pulse_update();
    tick(4);
    check("t4_en_idle", O_busy, 0);
    check("t4_en_no_reads", n_issued - i0, 0);
    I_enable = 1'b1;
    tick(1);
    check("t4_en_start", O_frame_start, 1);
    wait_frames(d0 + 1, 100);
    tick(2);
    s0 = n_starts; i0 = n_issued;
    I_data_valid = 1'b0;
    pulse_update();
    tick(4);
    check("t4_dv_no_start", n_starts - s0, 0);
    check("t4_dv_no_reads", n_issued - i0, 0);
    I_data_valid = 1'b1;
    tick(1);
    check("t4_dv_start", O_frame_start, 1);
    wait_frames(d0 + 2, 100);
    tick(2);

    // 5: reset after three beats abandons the frame
    a0 = n_accepted; d0 = n_done;
    pulse_update();
    for (int i = 0; i < 50; i++) begin
      if (n_accepted - a0 >= 3) break;
      tick(1);
    end
    check("t5_three_beats", n_accepted - a0, 3);
    I_rst_n = 1'b0;
    #1;
    chk_zero("t5_reset_outputs");
    sb.delete();
    n_issued = n_accepted;
    stalled_prev = 1'b0;
    tick(3);
    check("t5_no_done", n_done, d0);
    I_rst_n = 1'b1;
    tick(1);
    a0 = n_accepted;
    pulse_update();
    check("t5_restart", O_frame_start, 1);
    check("t5_restart_addr", bus.O_read_address, 0);
    wait_frames(d0 + 1, 100);
    check("t5_beats", n_accepted - a0, AN);

    // 6: ready low for 20 cycles: credit limits reads to FIFO_DEPTH
    tick(2);
    bus.I_lane_ready = 1'b0;
    a0 = n_accepted; d0 = n_done; i0 = n_issued;
    pulse_update();
    tick(19);
    check("t6_reads_stalled", n_issued - i0, FD);
    check("t6_ren_low", bus.O_read_enable, 0);
    bus.I_lane_ready = 1'b1;
    wait_frames(d0 + 1, 100);
    check("t6_beats", n_accepted - a0, AN);
    check("t6_sb_empty", sb.size(), 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
